// File: rtl/uart_rx.sv
// 8N1 UART receiver: three-flop line synchroniser, mid-bit start qualification,
// centre sampling of data bits, stop-bit check with done / framing-error strobes.
module uart_rx #(
  parameter int CLK_FREQ = 20000000,
  parameter int UART_BPS = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rxd,
  output logic [7:0] uart_rx_data,
  output logic       uart_rx_done,
  output logic       uart_rx_frame_err,
  output logic       uart_rx_busy
);

  localparam int BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
  localparam int HALF_CNT     = BAUD_CNT_MAX / 2;
  localparam logic [15:0] BAUD_LAST = 16'(BAUD_CNT_MAX - 1);
  localparam logic [15:0] HALF_LAST = 16'(HALF_CNT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t      r_state;
  logic        r_rxd_meta;
  logic        r_rxd_s;
  logic        r_rxd_d;
  logic [15:0] r_baud_cnt;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_shift;

  logic w_fall;
  logic w_half_end;
  logic w_baud_end;

  assign w_fall     = ~r_rxd_s & r_rxd_d;
  assign w_half_end = (r_baud_cnt == HALF_LAST);
  assign w_baud_end = (r_baud_cnt == BAUD_LAST);

  // Reset to the idle (high) level so release on an idle line is not an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rxd_meta <= 1'b1;
      r_rxd_s    <= 1'b1;
      r_rxd_d    <= 1'b1;
    end else begin
      r_rxd_meta <= uart_rxd;
      r_rxd_s    <= r_rxd_meta;
      r_rxd_d    <= r_rxd_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state           <= IDLE;
      r_baud_cnt        <= '0;
      r_bit_cnt         <= '0;
      r_shift           <= '0;
      uart_rx_data      <= '0;
      uart_rx_done      <= 1'b0;
      uart_rx_frame_err <= 1'b0;
      uart_rx_busy      <= 1'b0;
    end else begin
      uart_rx_done      <= 1'b0;
      uart_rx_frame_err <= 1'b0;
      uart_rx_busy      <= (r_state != IDLE);
      case (r_state)
        IDLE: begin
          r_baud_cnt <= '0;
          if (w_fall) r_state <= START;
        end
        START: begin
          if (w_half_end) begin
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            // A high line at mid-start means the low pulse was a glitch.
            r_state    <= r_rxd_s ? IDLE : DATA;
          end else begin
            r_baud_cnt <= r_baud_cnt + 16'd1;
          end
        end
        DATA: begin
          if (w_baud_end) begin
            r_baud_cnt <= '0;
            r_shift    <= {r_rxd_s, r_shift[7:1]};
            r_bit_cnt  <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) r_state <= STOP;
          end else begin
            r_baud_cnt <= r_baud_cnt + 16'd1;
          end
        end
        STOP: begin
          if (w_baud_end) begin
            r_baud_cnt <= '0;
            r_state    <= IDLE;
            if (r_rxd_s) begin
              uart_rx_data <= r_shift;
              uart_rx_done <= 1'b1;
            end else begin
              uart_rx_frame_err <= 1'b1;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + 16'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
